apb_gpio_slave: RTL and testbench

- APB completer that owns the GPIO register bank and pins; the far end of the APB_Protocol master's transfers.
- Decodes PSEL/PENABLE/PWRITE/PADDR and inserts a programmable number of wait states through PREADY.
- Drives pin outputs and output enables, and samples pin inputs through a 2-flop synchronizer.
- Latches edge events into sticky interrupt status and raises a level interrupt.

---
 rtl/apb_gpio_pkg.sv | 23 ++
 rtl/gpio_sync_edge.sv | 33 +++
 rtl/apb_gpio_slave.sv | 141 ++++++++++++++
 tb/tb_apb_gpio_slave.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/apb_gpio_pkg.sv
// apb_gpio_pkg: shared register offsets, FSM state type and wait-state limits for the APB GPIO slave
// Contents: GPIO_*_OFS byte offsets of the register bank, GPIO_MAX_WAIT / GPIO_CNT_W
//           wait-counter limits, apb_state_e FSM states, gpio_bad_ofs offset checker.
package apb_gpio_pkg;

   localparam logic [4:0] GPIO_DATA_OUT_OFS   = 5'h00;
   localparam logic [4:0] GPIO_DIR_OFS        = 5'h04;
   localparam logic [4:0] GPIO_DATA_IN_OFS    = 5'h08;
   localparam logic [4:0] GPIO_IRQ_EN_OFS     = 5'h0C;
   localparam logic [4:0] GPIO_IRQ_STATUS_OFS = 5'h10;
   localparam logic [4:0] GPIO_EDGE_SEL_OFS   = 5'h14;

   localparam int GPIO_MAX_WAIT = 15;
   localparam int GPIO_CNT_W    = 4;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;

   // Offset-level error: misaligned, past the last register, or a write to the read-only input bank.
   function automatic logic gpio_bad_ofs(input logic [4:0] ofs, input logic wr);
      return (ofs[1:0] != 2'b00) || (ofs > GPIO_EDGE_SEL_OFS) || (wr && ofs == GPIO_DATA_IN_OFS);
   endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// gpio_sync_edge: two-flop pin synchronizer with per-pin selectable edge detection
// Ports: PCLK rising-edge clock; PRESETn async active-low reset; pin_in raw asynchronous pins;
//        edge_sel per-pin polarity (1 rising, 0 falling); sync synchronized pins;
//        edge_evt one-cycle pulse per pin on the selected edge.
module gpio_sync_edge #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   input  logic [DATA_WIDTH-1:0] pin_in,
   input  logic [DATA_WIDTH-1:0] edge_sel,
   output logic [DATA_WIDTH-1:0] sync,
   output logic [DATA_WIDTH-1:0] edge_evt
);

   logic [DATA_WIDTH-1:0] sync1;
   logic [DATA_WIDTH-1:0] prev;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         sync1 <= '0;
         sync  <= '0;
         prev  <= '0;
      end else begin
         sync1 <= pin_in;
         sync  <= sync1;
         prev  <= sync;
      end
   end

   assign edge_evt = (edge_sel & sync & ~prev) | (~edge_sel & ~sync & prev);

endmodule

// File: rtl/apb_gpio_slave.sv
// apb_gpio_slave: APB completer owning the GPIO register bank, pins and edge interrupts
// Ports: PCLK/PRESETn clock and async active-low reset; PSEL/PENABLE/PWRITE/PADDR/PWDATA APB request;
//        PRDATA/PREADY/PSLVERR APB response; gpio_in async pins; gpio_out/gpio_oe pin drive
//        and enable; irq level interrupt |(IRQ_STATUS & IRQ_EN), registered.
module apb_gpio_slave
   import apb_gpio_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int WAIT_STATES = 1
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   input  logic                  PSEL,
   input  logic                  PENABLE,
   input  logic                  PWRITE,
   input  logic [ADDR_WIDTH-1:0] PADDR,
   input  logic [DATA_WIDTH-1:0] PWDATA,
   output logic [DATA_WIDTH-1:0] PRDATA,
   output logic                  PREADY,
   output logic                  PSLVERR,
   input  logic [DATA_WIDTH-1:0] gpio_in,
   output logic [DATA_WIDTH-1:0] gpio_out,
   output logic [DATA_WIDTH-1:0] gpio_oe,
   output logic                  irq
);

   localparam int WS_EFF = (WAIT_STATES > GPIO_MAX_WAIT) ? GPIO_MAX_WAIT : WAIT_STATES;
   localparam logic [GPIO_CNT_W-1:0] WS_LD = GPIO_CNT_W'(WS_EFF);

   apb_state_e state, state_n;
   logic [GPIO_CNT_W-1:0] cnt, cnt_n;
   logic cap, setup, live, ready;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic wr_q, wr_d;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic err_q, err_d, commit, rd_next;
   logic [DATA_WIDTH-1:0] prdata_q, rdata_d;
   logic [DATA_WIDTH-1:0] data_out, dir, irq_en, irq_status, edge_sel;
   logic [DATA_WIDTH-1:0] data_in, edge_evt, w1c_mask;

   gpio_sync_edge #(.DATA_WIDTH(DATA_WIDTH)) u_sync (
      .PCLK     (PCLK),
      .PRESETn  (PRESETn),
      .pin_in   (gpio_in),
      .edge_sel (edge_sel),
      .sync     (data_in),
      .edge_evt (edge_evt)
   );

   assign setup = PSEL && !PENABLE;
   assign live  = PSEL && PENABLE;
   // The counter is armed at capture, so the first access cycle is already a ready
   // candidate and PREADY lands on access cycle WAIT_STATES+1.
   assign ready = (state != IDLE) && live && (cnt == '0);

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      cap     = 1'b0;
      if (setup) begin
         state_n = SETUP;
         cnt_n   = WS_LD;
         cap     = 1'b1;
      end else if (state != IDLE) begin
         if (!live || cnt == '0) begin
            state_n = IDLE;
            cnt_n   = '0;
         end else begin
            state_n = ACCESS;
            cnt_n   = cnt - GPIO_CNT_W'(1);
         end
      end
   end

   // addr_d/wr_d are what the capture registers will hold next cycle, so read data
   // can be registered one cycle ahead and be valid exactly in the PREADY cycle.
   assign addr_d  = cap ? PADDR : addr_q;
   assign wr_d    = cap ? PWRITE : wr_q;
   assign err_q   = (|(addr_q >> 5)) || gpio_bad_ofs(addr_q[4:0], wr_q);
   assign err_d   = (|(addr_d >> 5)) || gpio_bad_ofs(addr_d[4:0], wr_d);
   assign commit  = ready && wr_q && !err_q;
   assign rd_next = (state_n != IDLE) && (cnt_n == '0) && !wr_d && !err_d;

   always_comb begin
      rdata_d = (addr_d[4:0] == GPIO_DATA_OUT_OFS)   ? data_out   :
                (addr_d[4:0] == GPIO_DIR_OFS)        ? dir        :
                (addr_d[4:0] == GPIO_DATA_IN_OFS)    ? data_in    :
                (addr_d[4:0] == GPIO_IRQ_EN_OFS)     ? irq_en     :
                (addr_d[4:0] == GPIO_IRQ_STATUS_OFS) ? irq_status :
                (addr_d[4:0] == GPIO_EDGE_SEL_OFS)   ? edge_sel   : '0;
   end

   // Clear mask first, then OR in new events: a same-cycle set beats the W1C.
   assign w1c_mask = (commit && addr_q[4:0] == GPIO_IRQ_STATUS_OFS) ? wdata_q : '0;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state    <= IDLE;
         cnt      <= '0;
         addr_q   <= '0;
         wr_q     <= 1'b0;
         wdata_q  <= '0;
         prdata_q <= '0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         addr_q   <= addr_d;
         wr_q     <= wr_d;
         wdata_q  <= cap ? PWDATA : wdata_q;
         prdata_q <= rd_next ? rdata_d : '0;
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         data_out   <= '0;
         dir        <= '0;
         irq_en     <= '0;
         edge_sel   <= '0;
         irq_status <= '0;
         gpio_out   <= '0;
         gpio_oe    <= '0;
         irq        <= 1'b0;
      end else begin
         data_out   <= (commit && addr_q[4:0] == GPIO_DATA_OUT_OFS) ? wdata_q : data_out;
         dir        <= (commit && addr_q[4:0] == GPIO_DIR_OFS) ? wdata_q : dir;
         irq_en     <= (commit && addr_q[4:0] == GPIO_IRQ_EN_OFS) ? wdata_q : irq_en;
         edge_sel   <= (commit && addr_q[4:0] == GPIO_EDGE_SEL_OFS) ? wdata_q : edge_sel;
         irq_status <= (irq_status & ~w1c_mask) | edge_evt;
         gpio_out   <= data_out & dir;
         gpio_oe    <= dir;
         irq        <= |(irq_status & irq_en);
      end
   end

   assign PREADY  = ready;
   assign PSLVERR = ready && err_q;
   assign PRDATA  = ready ? prdata_q : '0;

endmodule

// File: tb/tb_apb_gpio_slave.sv
// tb_apb_gpio_slave: table-driven APB scoreboard bench for apb_gpio_slave
module tb_apb_gpio_slave;

   localparam int WS = 1;

   logic        PCLK, PRESETn, PSEL, PENABLE, PWRITE;
   logic [31:0] PADDR, PWDATA, PRDATA, gpio_in, gpio_out, gpio_oe;
   logic        PREADY, PSLVERR, irq;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic        rd;
      logic [31:0] rdata;
      logic        err;
   } exp_t;
   exp_t exp_q[$];

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [31:0] wdata;
      logic [31:0] gpio;
      int          pre;
      logic [31:0] rdata;
      logic        err;
   } vec_t;
   localparam int NV = 19;
   vec_t tbl[NV];

   apb_gpio_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .WAIT_STATES(WS)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic apb(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic [31:0] er, input logic ee);
      exp_t e;
      int n;
      bit done;
      exp_q.push_back('{rd: !w, rdata: er, err: ee});
      @(posedge PCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PADDR = a; PWRITE = w; PWDATA = d;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      n = 0;
      done = 1'b0;
      while (!done && n < 40) begin
         @(negedge PCLK);
         n++;
         if (PREADY) done = 1'b1;
      end
      e = exp_q.pop_front();
      if (!done) check("pready_timeout", 32'(n), 32'(WS + 1));
      else begin
         check("latency", 32'(n), 32'(WS + 1));
         if (e.rd) check("prdata", PRDATA, e.rdata);
         check("pslverr", {31'b0, PSLVERR}, {31'b0, e.err});
      end
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   initial begin
      tbl[0]  = '{32'h00,  1'b0, 32'h0,  32'h0,  0, 32'h9,  1'b0};
      tbl[1]  = '{32'h04,  1'b0, 32'h0,  32'h0,  0, 32'hF,  1'b0};
      tbl[2]  = '{32'h1C,  1'b1, 32'h55, 32'h0,  0, 32'h0,  1'b1};
      tbl[3]  = '{32'h02,  1'b1, 32'h55, 32'h0,  0, 32'h0,  1'b1};
      tbl[4]  = '{32'h20,  1'b0, 32'h0,  32'h0,  0, 32'h0,  1'b1};
      tbl[5]  = '{32'h08,  1'b1, 32'h1,  32'h0,  0, 32'h0,  1'b1};
      tbl[6]  = '{32'h100, 1'b0, 32'h0,  32'h0,  0, 32'h0,  1'b1};
      tbl[7]  = '{32'h18,  1'b0, 32'h0,  32'h0,  0, 32'h0,  1'b1};
      tbl[8]  = '{32'h00,  1'b0, 32'h0,  32'h0,  0, 32'h9,  1'b0};
      tbl[9]  = '{32'h04,  1'b0, 32'h0,  32'h0,  0, 32'hF,  1'b0};
      tbl[10] = '{32'h08,  1'b0, 32'h0,  32'hA5, 3, 32'hA5, 1'b0};
      tbl[11] = '{32'h10,  1'b0, 32'h0,  32'hA5, 0, 32'h0,  1'b0};
      tbl[12] = '{32'h10,  1'b0, 32'h0,  32'h0,  4, 32'hA5, 1'b0};
      tbl[13] = '{32'h10,  1'b1, 32'hFF, 32'h0,  0, 32'h0,  1'b0};
      tbl[14] = '{32'h10,  1'b0, 32'h0,  32'h0,  0, 32'h0,  1'b0};
      tbl[15] = '{32'h0C,  1'b1, 32'h1,  32'h0,  0, 32'h0,  1'b0};
      tbl[16] = '{32'h0C,  1'b0, 32'h0,  32'h0,  0, 32'h1,  1'b0};
      tbl[17] = '{32'h14,  1'b1, 32'h1,  32'h0,  0, 32'h0,  1'b0};
      tbl[18] = '{32'h14,  1'b0, 32'h0,  32'h0,  0, 32'h1,  1'b0};

      PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      PADDR = '0; PWDATA = '0; gpio_in = '0;
      repeat (3) @(posedge PCLK);
      @(negedge PCLK);
      check("rst_prdata", PRDATA, 32'h0);
      check("rst_pready", {31'b0, PREADY}, 32'h0);
      check("rst_pslverr", {31'b0, PSLVERR}, 32'h0);
      check("rst_irq", {31'b0, irq}, 32'h0);
      check("rst_gpio_out", gpio_out, 32'h0);
      check("rst_gpio_oe", gpio_oe, 32'h0);
      @(posedge PCLK); #1;
      PRESETn = 1'b1;

      apb(32'h04, 1'b1, 32'hF, 32'h0, 1'b0);
      apb(32'h00, 1'b1, 32'h9, 32'h0, 1'b0);
      @(negedge PCLK);
      check("gpio_out_before", gpio_out, 32'h0);
      check("gpio_oe", gpio_oe, 32'hF);
      @(negedge PCLK);
      check("gpio_out_after", gpio_out, 32'h9);

      for (int i = 0; i < NV; i++) begin
         gpio_in = tbl[i].gpio;
         repeat (tbl[i].pre) @(posedge PCLK);
         apb(tbl[i].addr, tbl[i].wr, tbl[i].wdata, tbl[i].rdata, tbl[i].err);
      end

      // rising edge on pin 0 with EDGE_SEL[0]=1 and IRQ_EN[0]=1
      @(posedge PCLK); #1;
      gpio_in = 32'h1;
      repeat (4) @(negedge PCLK);
      check("irq_not_yet", {31'b0, irq}, 32'h0);
      @(negedge PCLK);
      check("irq_set", {31'b0, irq}, 32'h1);
      apb(32'h10, 1'b0, 32'h0, 32'h1, 1'b0);
      apb(32'h10, 1'b1, 32'h1, 32'h0, 1'b0);
      @(negedge PCLK);
      check("irq_hold", {31'b0, irq}, 32'h1);
      @(negedge PCLK);
      check("irq_clr", {31'b0, irq}, 32'h0);

      // event and W1C on the same edge: the set must survive
      @(posedge PCLK); #1;
      gpio_in = 32'h0;
      repeat (4) @(posedge PCLK);
      fork
         apb(32'h10, 1'b1, 32'h1, 32'h0, 1'b0);
         begin
            @(posedge PCLK); #1;
            gpio_in = 32'h1;
         end
      join
      apb(32'h10, 1'b0, 32'h0, 32'h1, 1'b0);
      check("irq_set_wins", {31'b0, irq}, 32'h1);

      // async reset during the wait cycle of a DIR write
      @(posedge PCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h04; PWRITE = 1'b1; PWDATA = 32'hFF;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      @(negedge PCLK);
      PRESETn = 1'b0;
      #1;
      check("mid_rst_pready", {31'b0, PREADY}, 32'h0);
      check("mid_rst_gpio_oe", gpio_oe, 32'h0);
      check("mid_rst_irq", {31'b0, irq}, 32'h0);
      PSEL = 1'b0; PENABLE = 1'b0;
      @(negedge PCLK);
      PRESETn = 1'b1;
      apb(32'h04, 1'b0, 32'h0, 32'h0, 1'b0);
      apb(32'h04, 1'b1, 32'hFF, 32'h0, 1'b0);
      apb(32'h04, 1'b0, 32'h0, 32'hFF, 1'b0);
      check("post_rst_gpio_oe", gpio_oe, 32'hFF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
